// File: rtl/vec_dot_pkg.sv
// Shared constants, helpers and FSM encoding for the vec_dot_acc dot-product engine.
package vec_dot_pkg;

  localparam int unsigned DefDw   = 16;
  localparam int unsigned DefFrac = 11;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/vec_dot_add_tree.sv
// Pipelined signed adder tree: one registered level per halving, with a valid/tag sideband.
module vec_dot_add_tree
  import vec_dot_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned IW    = 32,
  parameter int unsigned TW    = 2,
  localparam int unsigned TREE = clog2(LANES),
  localparam int unsigned OW   = IW + TREE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TW-1:0]          in_tag,
  input  logic [LANES*IW-1:0]    in_data,
  output logic                   out_valid,
  output logic [TW-1:0]          out_tag,
  output logic signed [OW-1:0]   out_sum
);

  logic signed [OW-1:0] lane_in [LANES];
  logic signed [OW-1:0] sum_d   [TREE][LANES/2];
  logic signed [OW-1:0] sum_q   [TREE][LANES/2];
  logic [TREE-1:0]      vld_d, vld_q;
  logic [TW-1:0]        tag_d   [TREE];
  logic [TW-1:0]        tag_q   [TREE];

  // Every level is carried at the final width so no level can overflow.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane_in[i] = OW'($signed(in_data[(int'(LANES) - i) * int'(IW) - 1 -: IW]));
    end
  end

  always_comb begin
    for (int l = 0; l < int'(TREE); l++) begin
      for (int i = 0; i < int'(LANES / 2); i++) begin
        sum_d[l][i] = '0;
      end
    end
    for (int i = 0; i < int'(LANES / 2); i++) begin
      sum_d[0][i] = lane_in[2 * i] + lane_in[2 * i + 1];
    end
    for (int l = 1; l < int'(TREE); l++) begin
      for (int i = 0; i < int'(LANES >> (l + 1)); i++) begin
        sum_d[l][i] = sum_q[l - 1][2 * i] + sum_q[l - 1][2 * i + 1];
      end
    end
  end

  always_comb begin
    vld_d[0] = in_valid;
    tag_d[0] = in_tag;
    for (int l = 1; l < int'(TREE); l++) begin
      vld_d[l] = vld_q[l - 1];
      tag_d[l] = tag_q[l - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int l = 0; l < int'(TREE); l++) begin
        tag_q[l] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
    sum_q <= sum_d;
  end

  assign out_valid = vld_q[TREE-1];
  assign out_tag   = tag_q[TREE-1];
  assign out_sum   = sum_q[TREE-1][0];

endmodule

// File: rtl/vec_dot_acc.sv
// Multi-beat signed fixed-point dot product: multiply, adder tree, accumulate,
// round half up, saturate, and present the result behind a valid/ready handshake.
module vec_dot_acc
  import vec_dot_pkg::*;
#(
  parameter int unsigned LANES     = 16,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned FRAC      = DefFrac,
  parameter int unsigned MAX_BEATS = 64,
  localparam int unsigned TREE     = clog2(LANES),
  localparam int unsigned ACC_W    = 2 * DW + TREE + clog2(MAX_BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   vec_a,
  input  logic [LANES*DW-1:0]   vec_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         dot_out,
  output logic                  sat,
  output logic                  beat_ovf
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = PW + TREE;
  localparam int unsigned CW = clog2(MAX_BEATS + 1);
  localparam int unsigned RW = ACC_W + 1;

  localparam logic signed [RW-1:0] Half   = (FRAC == 0) ? '0 : (RW'(1) << (FRAC - 1));
  localparam logic signed [RW-1:0] SatMax = RW'({1'b0, {(DW - 1){1'b1}}});
  localparam logic signed [RW-1:0] SatMin = ~SatMax;

  state_e state_d, state_q;
  logic in_ready_d, in_ready_q;
  logic out_valid_d, out_valid_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic ovf_d, ovf_q;
  logic [DW-1:0] dot_d, dot_q;
  logic sat_d, sat_q;
  logic bovf_d, bovf_q;

  logic [LANES*PW-1:0] mul_d, mul_q;
  logic mul_vld_d, mul_vld_q;
  logic [1:0] mul_tag_d, mul_tag_q;

  logic tree_vld;
  logic [1:0] tree_tag;
  logic signed [SW-1:0] tree_sum;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic acc_done_d, acc_done_q;
  logic signed [RW-1:0] rnd_d, rnd_q;
  logic rnd_vld_d, rnd_vld_q;

  logic accept, at_max, beat_last;
  logic [DW-1:0] sat_val;
  logic sat_hit;

  assign accept    = in_valid & in_ready_q;
  assign at_max    = (cnt_q == CW'(MAX_BEATS - 1));
  assign beat_last = in_last | at_max;

  always_comb begin
    mul_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      mul_d[(int'(LANES) - i) * int'(PW) - 1 -: PW] =
          $signed(vec_a[(int'(LANES) - i) * int'(DW) - 1 -: DW]) *
          $signed(vec_b[(int'(LANES) - i) * int'(DW) - 1 -: DW]);
    end
    mul_vld_d = accept;
    // Tag bit 1 marks the first beat of a vector, bit 0 the last.
    mul_tag_d = {state_q == StIdle, beat_last} & {2{accept}};
  end

  vec_dot_add_tree #(
    .LANES (LANES),
    .IW    (PW),
    .TW    (2)
  ) u_add_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mul_vld_q),
    .in_tag    (mul_tag_q),
    .in_data   (mul_q),
    .out_valid (tree_vld),
    .out_tag   (tree_tag),
    .out_sum   (tree_sum)
  );

  always_comb begin
    acc_d      = acc_q;
    acc_done_d = 1'b0;
    if (tree_vld) begin
      acc_d      = tree_tag[1] ? ACC_W'(tree_sum) : acc_q + ACC_W'(tree_sum);
      acc_done_d = tree_tag[0];
    end
    rnd_d     = (RW'(acc_q) + Half) >>> FRAC;
    rnd_vld_d = acc_done_q;
  end

  always_comb begin
    sat_hit = 1'b1;
    if (rnd_q > SatMax) begin
      sat_val = SatMax[DW-1:0];
    end else if (rnd_q < SatMin) begin
      sat_val = SatMin[DW-1:0];
    end else begin
      sat_val = rnd_q[DW-1:0];
      sat_hit = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    dot_d       = dot_q;
    sat_d       = sat_q;
    bovf_d      = bovf_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          if (beat_last) begin
            state_d    = StDrain;
            in_ready_d = 1'b0;
            cnt_d      = '0;
            ovf_d      = ~in_last;
          end else begin
            state_d = StRun;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (rnd_vld_q) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          dot_d       = sat_val;
          sat_d       = sat_hit;
          bovf_d      = ovf_q;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      dot_q       <= '0;
      sat_q       <= 1'b0;
      bovf_q      <= 1'b0;
      mul_q       <= '0;
      mul_vld_q   <= 1'b0;
      mul_tag_q   <= '0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      rnd_q       <= '0;
      rnd_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      dot_q       <= dot_d;
      sat_q       <= sat_d;
      bovf_q      <= bovf_d;
      mul_q       <= mul_d;
      mul_vld_q   <= mul_vld_d;
      mul_tag_q   <= mul_tag_d;
      acc_q       <= acc_d;
      acc_done_q  <= acc_done_d;
      rnd_q       <= rnd_d;
      rnd_vld_q   <= rnd_vld_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dot_out   = dot_q;
  assign sat       = sat_q;
  assign beat_ovf  = bovf_q;

endmodule

// File: tb/tb_vec_dot_acc.sv
// Scoreboard bench for vec_dot_acc: default build plus a MAX_BEATS=4 build.
module tb_vec_dot_acc;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 11;
  localparam int unsigned VW    = LANES * DW;
  localparam longint      SMax  = (longint'(1) << (DW - 1)) - 1;
  localparam longint      SMin  = -(longint'(1) << (DW - 1));

  typedef struct packed {
    logic [DW-1:0] dot;
    logic          sat;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, sat, beat_ovf;
  logic [VW-1:0] vec_a, vec_b;
  logic [DW-1:0] dot_out;

  logic in1_valid, in1_ready, in1_last, out1_valid, out1_ready, sat1, ovf1;
  logic [VW-1:0] vec1_a, vec1_b;
  logic [DW-1:0] dot1;

  int n_vec = 0;
  int n_err = 0;
  res_t sb[$];
  res_t sb1[$];
  res_t e0, e1;
  longint acc_m = 0;
  bit vec_first = 1'b1;

  vec_dot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dot_out   (dot_out),
    .sat       (sat),
    .beat_ovf  (beat_ovf)
  );

  vec_dot_acc #(.MAX_BEATS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in_last   (in1_last),
    .vec_a     (vec1_a),
    .vec_b     (vec1_b),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .dot_out   (dot1),
    .sat       (sat1),
    .beat_ovf  (ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input longint acc, input logic ovf);
    res_t o;
    longint r;
    r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > SMax) begin
      o.dot = DW'(SMax);
      o.sat = 1'b1;
    end else if (r < SMin) begin
      o.dot = DW'(SMin);
      o.sat = 1'b1;
    end else begin
      o.dot = r[DW-1:0];
      o.sat = 1'b0;
    end
    o.ovf = ovf;
    return o;
  endfunction

  function automatic longint beat_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      s += longint'($signed(a[(int'(LANES) - i) * int'(DW) - 1 -: DW])) *
           longint'($signed(b[(int'(LANES) - i) * int'(DW) - 1 -: DW]));
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] mk_vec(input logic [DW-1:0] lane0, input logic [DW-1:0] rest);
    logic [VW-1:0] v;
    for (int i = 0; i < int'(LANES); i++) begin
      v[(int'(LANES) - i) * int'(DW) - 1 -: DW] = (i == 0) ? lane0 : rest;
    end
    return v;
  endfunction

  task automatic drive_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
    int k;
    vec_a    = a;
    vec_b    = b;
    in_last  = last;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (vec_first) acc_m = 0;
    acc_m += beat_sum(a, b);
    vec_first = last;
    if (last) sb.push_back(model(acc_m, 1'b0));
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid && sb.size() == 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check(tag, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        e0 = sb.pop_front();
        check("dot", 64'(dot_out), 64'(e0.dot));
        check("sat", 64'(sat), 64'(e0.sat));
        check("ovf", 64'(beat_ovf), 64'(e0.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out1_valid && out1_ready) begin
      if (sb1.size() == 0) begin
        check("unexpected_out4", 64'd1, 64'd0);
      end else begin
        e1 = sb1.pop_front();
        check("dot4", 64'(dot1), 64'(e1.dot));
        check("sat4", 64'(sat1), 64'(e1.sat));
        check("ovf4", 64'(ovf1), 64'(e1.ovf));
      end
    end
  end

  initial begin
    int n;
    bit seen;
    logic [VW-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    vec_a = '0;
    vec_b = '0;
    in1_valid = 1'b0;
    in1_last = 1'b0;
    out1_ready = 1'b1;
    vec1_a = '0;
    vec1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dot", 64'(dot_out), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_ovf", 64'(beat_ovf), 64'd0);
    check("rst_in1_ready", 64'(in1_ready), 64'd1);
    @(posedge clk);
    #1;

    // Scaling and latency: 16 * 1.0 * 0.5 = 8.0.
    drive_beat(mk_vec(16'h0800, 16'h0800), mk_vec(16'h0400, 16'h0400), 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 50);
    check("latency", 64'(n), 64'd7);
    check("basic_exp", 64'(sb.size() > 0 ? sb[0].dot : 16'h0), 64'h4000);
    wait_idle("basic_idle");

    drive_beat(mk_vec(16'h0800, 16'h0800), mk_vec(16'h0800, 16'h0800), 1'b1);
    wait_idle("sat_pos_idle");
    drive_beat(mk_vec(16'hF800, 16'hF800), mk_vec(16'h0800, 16'h0800), 1'b1);
    wait_idle("sat_neg_idle");
    drive_beat(mk_vec(16'h0001, 16'h0000), mk_vec(16'h0400, 16'h0000), 1'b1);
    wait_idle("rnd_up_idle");
    drive_beat(mk_vec(16'h0001, 16'h0000), mk_vec(16'h03FF, 16'h0000), 1'b1);
    wait_idle("rnd_dn_idle");

    // Two back-to-back beats with the output held off for five cycles.
    out_ready = 1'b0;
    drive_beat(mk_vec(16'h0100, 16'h0100), mk_vec(16'h0800, 16'h0800), 1'b0);
    drive_beat(mk_vec(16'h0100, 16'h0100), mk_vec(16'h0800, 16'h0800), 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_dot", 64'(dot_out), 64'h2000);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_ready_after", 64'(in_ready), 64'd1);
    check("bp_valid_after", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Random multi-beat vectors; small magnitudes plus one full-range set.
    for (int v = 0; v < 6; v++) begin
      n = int'($urandom_range(1, 3));
      for (int bt = 0; bt < n; bt++) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (v == 5) begin
            ra[(int'(LANES) - i) * int'(DW) - 1 -: DW] = DW'($urandom);
            rb[(int'(LANES) - i) * int'(DW) - 1 -: DW] = DW'($urandom);
          end else begin
            ra[(int'(LANES) - i) * int'(DW) - 1 -: DW] = DW'(int'($urandom_range(0, 1023)) - 512);
            rb[(int'(LANES) - i) * int'(DW) - 1 -: DW] = DW'(int'($urandom_range(0, 1023)) - 512);
          end
        end
        drive_beat(ra, rb, (bt == n - 1) ? 1'b1 : 1'b0);
      end
      wait_idle("rand_idle");
    end

    // Reset two cycles after the last beat: the result must never appear.
    drive_beat(mk_vec(16'h0800, 16'h0800), mk_vec(16'h0800, 16'h0800), 1'b1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= out_valid;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    sb.delete();
    vec_first = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 10; c++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    drive_beat(mk_vec(16'h0800, 16'h0800), mk_vec(16'h0400, 16'h0400), 1'b1);
    wait_idle("post_abort_idle");

    // MAX_BEATS=4 build: four beats without last force termination.
    vec1_a = mk_vec(16'h0800, 16'h0000);
    vec1_b = mk_vec(16'h0800, 16'h0000);
    in1_last = 1'b0;
    for (int bt = 0; bt < 4; bt++) begin
      in1_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in1_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("ovf_accept", 64'(in1_ready), 64'd1);
      @(posedge clk);
      #1;
      in1_valid = 1'b0;
    end
    sb1.push_back(model(4 * (longint'(1) << 22), 1'b1));
    @(negedge clk);
    check("ovf_drain_ready", 64'(in1_ready), 64'd0);
    n = 0;
    while (sb1.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ovf_result_seen", 64'(sb1.size()), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ovf_ready_after", 64'(in1_ready), 64'd1);

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
